// File: rtl/switch_debounce_bank.sv
// Switch conditioning bank: two-flop synchroniser plus an independent
// persistence counter per bit, producing a clean registered vector.
module switch_debounce_bank #(
  parameter int LENGTH          = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LENGTH-1:0] sw_in,
  output logic [LENGTH-1:0] sw_out,
  output logic              changed,
  output logic              all_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [LENGTH-1:0] sync1_q, sync1_d;
  logic [LENGTH-1:0] sync2_q, sync2_d;
  logic [LENGTH-1:0] sw_out_q, sw_out_d;
  logic              changed_q, changed_d;
  logic [CNT_W-1:0]  cnt_q [LENGTH];
  logic [CNT_W-1:0]  cnt_d [LENGTH];

  always_comb begin
    sync1_d  = sw_in;
    sync2_d  = sync1_q;
    sw_out_d = sw_out_q;
    for (int i = 0; i < LENGTH; i++) begin
      cnt_d[i] = '0;
      // A mismatch must persist DEBOUNCE_CYCLES edges; any matching cycle restarts it.
      if (sync2_q[i] != sw_out_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          sw_out_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    changed_d = |(sw_out_d ^ sw_out_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sw_out_q  <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < LENGTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sw_out_q  <= sw_out_d;
      changed_q <= changed_d;
      for (int i = 0; i < LENGTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    all_stable = 1'b1;
    for (int i = 0; i < LENGTH; i++) begin
      if (cnt_q[i] != '0) all_stable = 1'b0;
    end
  end

  assign sw_out  = sw_out_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_switch_debounce_bank.sv
// Directed bench for switch_debounce_bank with LENGTH=8, DEBOUNCE_CYCLES=4.
module tb_switch_debounce_bank;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw_in;
  logic [7:0] sw_out;
  logic       changed;
  logic       all_stable;

  int total = 0;
  int bad   = 0;

  switch_debounce_bank #(.LENGTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_in      (sw_in),
    .sw_out     (sw_out),
    .changed    (changed),
    .all_stable (all_stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_out, input logic e_chg,
                         input logic e_stb);
    chk({tag, ".sw_out"}, {24'd0, sw_out}, {24'd0, e_out});
    chk({tag, ".changed"}, {31'd0, changed}, {31'd0, e_chg});
    chk({tag, ".all_stable"}, {31'd0, all_stable}, {31'd0, e_stb});
  endtask

  initial begin
    rst_n = 1'b0;
    sw_in = 8'hFF;

    // Reset holds everything clear even with inputs high.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("reset", 8'h00, 1'b0, 1'b1);
    end

    rst_n = 1'b1;
    sw_in = 8'h00;
    step();
    step();
    chk_out("idle", 8'h00, 1'b0, 1'b1);

    // Clean step 00->FF: visible after E5.
    sw_in = 8'hFF;
    step(); chk_out("step_e0", 8'h00, 1'b0, 1'b1);
    step(); chk_out("step_e1", 8'h00, 1'b0, 1'b1);
    step(); chk_out("step_e2", 8'h00, 1'b0, 1'b0);
    step(); chk_out("step_e3", 8'h00, 1'b0, 1'b0);
    step(); chk_out("step_e4", 8'h00, 1'b0, 1'b0);
    step(); chk_out("step_e5", 8'hFF, 1'b1, 1'b1);
    step(); chk_out("step_e6", 8'hFF, 1'b0, 1'b1);

    // Return to 00.
    sw_in = 8'h00;
    repeat (5) step();
    chk_out("fall_e4", 8'hFF, 1'b0, 1'b0);
    step(); chk_out("fall_e5", 8'h00, 1'b1, 1'b1);
    step(); chk_out("fall_e6", 8'h00, 1'b0, 1'b1);

    // Glitch: bit3 high for three cycles only.
    sw_in = 8'h08;
    step(); chk_out("glitch_e0", 8'h00, 1'b0, 1'b1);
    step(); chk_out("glitch_e1", 8'h00, 1'b0, 1'b1);
    step(); chk_out("glitch_e2", 8'h00, 1'b0, 1'b0);
    sw_in = 8'h00;
    step(); chk_out("glitch_e3", 8'h00, 1'b0, 1'b0);
    step(); chk_out("glitch_e4", 8'h00, 1'b0, 1'b0);
    step(); chk_out("glitch_e5", 8'h00, 1'b0, 1'b1);
    step(); chk_out("glitch_e6", 8'h00, 1'b0, 1'b1);
    step(); chk_out("glitch_e7", 8'h00, 1'b0, 1'b1);

    // Independent bits: bit0 two cycles ahead of bit7.
    sw_in = 8'h01;
    step();
    step();
    sw_in = 8'h81;
    step();
    step();
    step(); chk_out("indep_e4", 8'h00, 1'b0, 1'b0);
    step(); chk_out("indep_e5", 8'h01, 1'b1, 1'b0);
    chk("indep_e5.and", {31'd0, &sw_out}, 32'd0);
    step(); chk_out("indep_e6", 8'h01, 1'b0, 1'b0);
    step(); chk_out("indep_e7", 8'h81, 1'b1, 1'b1);
    chk("indep_e7.and", {31'd0, &sw_out}, 32'd0);
    step(); chk_out("indep_e8", 8'h81, 1'b0, 1'b1);

    // Reset after three counting edges discards progress.
    sw_in = 8'hFF;
    repeat (5) step();
    chk_out("midrst_pre", 8'h81, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(); chk_out("midrst_in", 8'h00, 1'b0, 1'b1);
    rst_n = 1'b1;
    step(); chk_out("midrst_e0", 8'h00, 1'b0, 1'b1);
    step();
    step(); chk_out("midrst_e2", 8'h00, 1'b0, 1'b0);
    step();
    step(); chk_out("midrst_e4", 8'h00, 1'b0, 1'b0);
    step(); chk_out("midrst_e5", 8'hFF, 1'b1, 1'b1);
    step(); chk_out("midrst_e6", 8'hFF, 1'b0, 1'b1);

    // Simultaneous multi-bit change FF->5A.
    sw_in = 8'h5A;
    repeat (5) step();
    chk_out("multi_e4", 8'hFF, 1'b0, 1'b0);
    step(); chk_out("multi_e5", 8'h5A, 1'b1, 1'b1);
    step(); chk_out("multi_e6", 8'h5A, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_debounce_bank.md
Name: switch_debounce_bank

Overview:
- Upstream conditioning stage for the AND-chain detector.
- Takes LENGTH raw, asynchronous board switch/button levels and synchronises each bit into the clock domain.
- Debounces each bit independently and presents a clean, registered LENGTH-bit vector; this vector drives the detector's `a` input directly.
- Also flags when the debounced vector changes and when all inputs are settled.

Parameters:
- LENGTH, 8, number of independent input bits; must match the downstream detector width.
- DEBOUNCE_CYCLES, 16, consecutive cycles a new level must persist before it is accepted; legal range ≥2.
- CNT_W (localparam), $clog2(DEBOUNCE_CYCLES)+1, width of each per-bit counter; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- sw_in  input  LENGTH  raw asynchronous switch levels.
- sw_out  output  LENGTH  debounced, registered levels; feeds the detector `a`.
- changed  output  1  one-cycle pulse: sw_out took a new value this cycle.
- all_stable  output  1  high when no bit has a pending (counting) mismatch.

Behaviour:
- Reset (rst_n=0 sampled at rising edge) clears the following, regardless of sw_in:
  - both synchroniser stages
  - all counters
  - sw_out = 0
  - changed = 0
- While in reset, all_stable reads 1 because all counters are 0.
- Reset mid-count discards the count; no partial state survives.
- Synchroniser: two flops per bit, sync1 <= sw_in, sync2 <= sync1. Only sync2 is used downstream.
- Per-bit counter cnt[i], evaluated each edge:
  - sync2[i] == sw_out[i]: cnt[i] <= 0.
  - sync2[i] != sw_out[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != sw_out[i] and cnt[i] == DEBOUNCE_CYCLES-1: sw_out[i] <= sync2[i], cnt[i] <= 0.
- Glitch rejection: a mismatch that ends before acceptance returns cnt to 0 on the first matching cycle. sw_out does not change and changed does not pulse.
- Latency: sw_in changes and is held before edge E0 (first sampling edge).
  - sync2 shows the new level after E1.
  - sw_out updates at edge E(DEBOUNCE_CYCLES+1), the (DEBOUNCE_CYCLES+2)th sampling edge.
  - Example, D=4: sw_out is visible after the 6th edge.
- changed is registered and asserted on the same edge that updates any sw_out bit, so it is high exactly in the first cycle the new sw_out is visible.
  - Several bits accepted on the same edge produce a single one-cycle pulse.
  - Acceptances on consecutive edges produce changed high on consecutive cycles.
- all_stable is combinational: 1 when every cnt[i]==0, else 0.
- Bits are fully independent; a bounce on one bit never resets or delays another bit's counter.
- Sustained toggling with period < DEBOUNCE_CYCLES never updates that bit.
- Counter cannot overflow: it is cleared on acceptance at DEBOUNCE_CYCLES-1.

Test Plan:
- Bench settings for all scenarios: LENGTH=8, DEBOUNCE_CYCLES=4.
- Reset: sw_in=8'hFF during rst_n=0 for 3 edges -> sw_out=8'h00, changed=0, all_stable=1 throughout reset.
- Clean step: after reset release, sw_in 8'h00->8'hFF held before edge E0 -> sw_out=8'hFF after edge E5 (not E4), changed=1 for exactly that one cycle, all_stable=0 from after E2 until after E5.
- Glitch: sw_out=8'h00, sw_in[3] pulses high for 3 cycles then low -> sw_out stays 8'h00, changed never asserts, all_stable returns to 1.
- Independent bits: bit0 set 2 cycles before bit7 -> sw_out goes 8'h00->8'h01->8'h81 on edges 2 apart, two separate changed pulses; downstream AND output stays 0.
- Reset mid-count: sw_in=8'hFF, rst_n pulsed low after 3 cycles of counting -> sw_out=8'h00; after release the full 6-edge latency applies again before sw_out=8'hFF.
- Simultaneous multi-bit: sw_in 8'hFF->8'h5A in one cycle -> sw_out=8'h5A on a single edge with a single one-cycle changed pulse.
